// File: rtl/cpu7_exu_eclwbtrk_pkg.sv
// Shared definitions for the EXU write-back tracker and its divide scoreboard.
// Register-index width, register count and the D-source match helper live here.
package cpu7_exu_eclwbtrk_pkg;

    localparam int REG_W = 5;
    localparam int NREG  = 32;

    typedef logic [REG_W-1:0] reg_idx_t;

    // A D-stage source hits a producer tag only when the source is actually
    // read and is not r0 (r0 is hardwired zero and never has a producer).
    function automatic logic src_match(input reg_idx_t src,
                                       input logic     src_rd,
                                       input reg_idx_t tag);
        return src_rd && (src != '0) && (src == tag);
    endfunction

endpackage

// File: rtl/cpu7_exu_eclsb.sv
// Long-latency (divide) busy scoreboard: one busy bit per architectural
// register, set when a divide leaves E and cleared when it writes back.
// A same-cycle set and clear of one index leaves the bit set, since the
// issuing op is a newer producer than the one completing. Bit 0 never sets.
module cpu7_exu_eclsb
    import cpu7_exu_eclwbtrk_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     set_en,
    input  reg_idx_t set_idx,
    input  logic     clr_en,
    input  reg_idx_t clr_idx,
    input  reg_idx_t rs1_d,
    input  reg_idx_t rs2_d,
    input  logic     rs1_rd_d,
    input  logic     rs2_rd_d,
    output logic     hit
);

    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    // Next busy vector: clear first, then set, so set wins on a collision.
    always_comb begin
        sb_next = sb;
        if (clr_en) begin
            sb_next[clr_idx] = 1'b0;
        end
        if (set_en) begin
            sb_next[set_idx] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

    // Read-port hit: an active, non-zero D source whose register is busy.
    always_comb begin
        hit = 1'b0;
        if (rs1_rd_d && (rs1_d != '0) && sb[rs1_d]) begin
            hit = 1'b1;
        end
        if (rs2_rd_d && (rs2_d != '0) && sb[rs2_d]) begin
            hit = 1'b1;
        end
    end

endmodule

// File: rtl/cpu7_exu_eclwbtrk.sv
// EXU write-back tracker: carries destination tags and write enables of
// in-flight instructions from E through M to W for the bypass selectors,
// and raises the D-stage interlock (load-use, M stall, optional divide
// scoreboard).
// Optional feature macro: CPU7_DIV_SCOREBOARD_EN enables the long-latency
// divide scoreboard and the divider write-back path into W.
module cpu7_exu_eclwbtrk
    import cpu7_exu_eclwbtrk_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     valid_e,
    input  reg_idx_t rd_e,
    input  logic     wen_e,
    input  logic     load_e,
    input  logic     stall_m,
    input  logic     flush,
    input  reg_idx_t rs1_d,
    input  reg_idx_t rs2_d,
    input  logic     rs1_rd_d,
    input  logic     rs2_rd_d,
    input  logic     div_issue_e,
    input  logic     div_done,
    input  reg_idx_t div_rd,
    output reg_idx_t rd_m,
    output logic     wen_m,
    output reg_idx_t rd_w,
    output logic     wen_w,
    output logic     stall_d
);

    // E writes a real register: r0 is never tracked.
    logic e_wr;
    // Write enable carried into M before the load mask; W consumes it raw.
    logic m_wen_in;
    logic m_wen_raw;
    logic m_load;
    // Load-use hazards against the E and M producers.
    logic e_load_hit;
    logic m_load_hit;
    // Divide scoreboard hit (constant 0 when the feature is compiled out).
    logic sb_hit;
    // Divider write-back steering into W.
    logic div_wb;

    assign e_wr = valid_e & wen_e & (rd_e != '0);

`ifdef CPU7_DIV_SCOREBOARD_EN
    // A divide's result only enters the pipe through the divider write-back.
    assign m_wen_in = e_wr & ~div_issue_e;
    assign div_wb   = div_done & (div_rd != '0);

    cpu7_exu_eclsb u_sb (
        .clk      (clk),
        .reset    (reset),
        .set_en   (div_issue_e & e_wr & ~flush & ~stall_m),
        .set_idx  (rd_e),
        .clr_en   (div_done),
        .clr_idx  (div_rd),
        .rs1_d    (rs1_d),
        .rs2_d    (rs2_d),
        .rs1_rd_d (rs1_rd_d),
        .rs2_rd_d (rs2_rd_d),
        .hit      (sb_hit)
    );
`else
    // Without the scoreboard divides are ordinary E ops.
    assign m_wen_in = e_wr;
    assign div_wb   = 1'b0;
    assign sb_hit   = 1'b0;

    logic unused_div;
    assign unused_div = &{1'b0, div_issue_e, div_done, div_rd};
`endif

    // M register: flush kills, stall_m holds, otherwise take E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_m      <= '0;
            m_wen_raw <= 1'b0;
            m_load    <= 1'b0;
        end else if (flush) begin
            m_wen_raw <= 1'b0;
            m_load    <= 1'b0;
        end else if (!stall_m) begin
            rd_m      <= rd_e;
            m_wen_raw <= m_wen_in;
            m_load    <= load_e & e_wr;
        end
    end

    // Loads are not bypassable from M; they become visible at W.
    assign wen_m = m_wen_raw & ~m_load;

    // W register: divider write-back first, then bubble on flush/stall,
    // otherwise move M into W (loads included). rd_w holds on a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_w  <= '0;
            wen_w <= 1'b0;
        end else if (div_wb) begin
            rd_w  <= div_rd;
            wen_w <= 1'b1;
        end else if (flush || stall_m) begin
            wen_w <= 1'b0;
        end else begin
            rd_w  <= rd_m;
            wen_w <= m_wen_raw;
        end
    end

    // Load-use hazard detection against the E-stage and M-stage loads.
    always_comb begin
        e_load_hit = 1'b0;
        m_load_hit = 1'b0;
        if (load_e && e_wr) begin
            e_load_hit = src_match(rs1_d, rs1_rd_d, rd_e) |
                         src_match(rs2_d, rs2_rd_d, rd_e);
        end
        if (m_load) begin
            m_load_hit = src_match(rs1_d, rs1_rd_d, rd_m) |
                         src_match(rs2_d, rs2_rd_d, rd_m);
        end
    end

    // D-stage interlock: any hazard, or M unable to advance.
    always_comb begin
        stall_d = stall_m | e_load_hit | m_load_hit | sb_hit;
    end

endmodule

// File: tb/tb_cpu7_exu_eclwbtrk.sv
// Directed bench for cpu7_exu_eclwbtrk. Inputs change on the falling edge,
// outputs are sampled 1 ns later, so registered outputs reflect the
// previous rising edge and stall_d reflects the current inputs.
module tb_cpu7_exu_eclwbtrk;

    logic       clk;
    logic       reset;
    logic       valid_e;
    logic [4:0] rd_e;
    logic       wen_e;
    logic       load_e;
    logic       stall_m;
    logic       flush;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic       rs1_rd_d;
    logic       rs2_rd_d;
    logic       div_issue_e;
    logic       div_done;
    logic [4:0] div_rd;
    logic [4:0] rd_m;
    logic       wen_m;
    logic [4:0] rd_w;
    logic       wen_w;
    logic       stall_d;

    int vec_cnt = 0;
    int err_cnt = 0;

    cpu7_exu_eclwbtrk dut (
        .clk         (clk),
        .reset       (reset),
        .valid_e     (valid_e),
        .rd_e        (rd_e),
        .wen_e       (wen_e),
        .load_e      (load_e),
        .stall_m     (stall_m),
        .flush       (flush),
        .rs1_d       (rs1_d),
        .rs2_d       (rs2_d),
        .rs1_rd_d    (rs1_rd_d),
        .rs2_rd_d    (rs2_rd_d),
        .div_issue_e (div_issue_e),
        .div_done    (div_done),
        .div_rd      (div_rd),
        .rd_m        (rd_m),
        .wen_m       (wen_m),
        .rd_w        (rd_w),
        .wen_w       (wen_w),
        .stall_d     (stall_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Move to the next falling edge and drive an E-stage op.
    task automatic drive_e(input logic v, input logic [4:0] rd, input logic wen, input logic ld);
        @(negedge clk);
        valid_e = v;
        rd_e    = rd;
        wen_e   = wen;
        load_e  = ld;
    endtask

    task automatic set_d(input logic [4:0] s1, input logic r1, input logic [4:0] s2, input logic r2);
        rs1_d    = s1;
        rs1_rd_d = r1;
        rs2_d    = s2;
        rs2_rd_d = r2;
    endtask

    task automatic idle_inputs();
        valid_e     = 1'b0;
        rd_e        = 5'd0;
        wen_e       = 1'b0;
        load_e      = 1'b0;
        stall_m     = 1'b0;
        flush       = 1'b0;
        div_issue_e = 1'b0;
        div_done    = 1'b0;
        div_rd      = 5'd0;
        set_d(5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic drain();
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (rd_m !== 5'd0 || wen_m !== 1'b0 || rd_w !== 5'd0 || wen_w !== 1'b0 || stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset: rd_m=%0d wen_m=%b rd_w=%0d wen_w=%b stall_d=%b, want all 0",
                     rd_m, wen_m, rd_w, wen_w, stall_d);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_alu_chain();
        drive_e(1'b1, 5'd5, 1'b1, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_t0_stall: got %b want 0", stall_d);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (rd_m !== 5'd5 || wen_m !== 1'b1 || stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_t1: rd_m=%0d wen_m=%b stall_d=%b want 5 1 0", rd_m, wen_m, stall_d);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (rd_w !== 5'd5 || wen_w !== 1'b1 || wen_m !== 1'b0) begin
            err_cnt++;
            $display("FAIL alu_t2: rd_w=%0d wen_w=%b wen_m=%b want 5 1 0", rd_w, wen_w, wen_m);
        end
        drain();
    endtask

    task automatic test_load_use();
        drive_e(1'b1, 5'd7, 1'b1, 1'b1);
        set_d(5'd7, 1'b1, 5'd0, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_use_t0: stall_d=%b want 1", stall_d);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1 || rd_m !== 5'd7 || wen_m !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_use_t1: stall_d=%b rd_m=%0d wen_m=%b want 1 7 0", stall_d, rd_m, wen_m);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0 || wen_w !== 1'b1 || rd_w !== 5'd7 || wen_m !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_use_t2: stall_d=%b wen_w=%b rd_w=%0d wen_m=%b want 0 1 7 0",
                     stall_d, wen_w, rd_w, wen_m);
        end
        drain();
        // rs2 port hits; an unread rs1 with the same index does not.
        drive_e(1'b1, 5'd10, 1'b1, 1'b1);
        set_d(5'd10, 1'b0, 5'd10, 1'b1);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_use_rs2: stall_d=%b want 1", stall_d);
        end
        set_d(5'd10, 1'b0, 5'd10, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL load_use_unread: stall_d=%b want 0", stall_d);
        end
        drain();
    endtask

    task automatic test_r0_filter();
        drive_e(1'b1, 5'd0, 1'b1, 1'b0);
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (wen_m !== 1'b0) begin
            err_cnt++;
            $display("FAIL r0_wen_m: got %b want 0", wen_m);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL r0_wen_w: got %b want 0", wen_w);
        end
        drive_e(1'b1, 5'd0, 1'b1, 1'b1);
        set_d(5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL r0_load_e: stall_d=%b want 0", stall_d);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL r0_load_m: stall_d=%b want 0", stall_d);
        end
        drain();
    endtask

    task automatic test_stall_m();
        drive_e(1'b1, 5'd9, 1'b1, 1'b0);
        drive_e(1'b1, 5'd11, 1'b1, 1'b0);
        stall_m = 1'b1;
        #1;
        vec_cnt++;
        if (rd_m !== 5'd9 || wen_m !== 1'b1 || stall_d !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_m_c0: rd_m=%0d wen_m=%b stall_d=%b want 9 1 1", rd_m, wen_m, stall_d);
        end
        @(negedge clk);
        #1;
        vec_cnt++;
        if (rd_m !== 5'd9 || wen_m !== 1'b1 || wen_w !== 1'b0 || stall_d !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_m_c1: rd_m=%0d wen_m=%b wen_w=%b stall_d=%b want 9 1 0 1",
                     rd_m, wen_m, wen_w, stall_d);
        end
        @(negedge clk);
        stall_m = 1'b0;
        #1;
        vec_cnt++;
        if (rd_m !== 5'd9 || wen_m !== 1'b1 || wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL stall_m_c2: rd_m=%0d wen_m=%b wen_w=%b want 9 1 0", rd_m, wen_m, wen_w);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (rd_w !== 5'd9 || wen_w !== 1'b1 || rd_m !== 5'd11 || wen_m !== 1'b1) begin
            err_cnt++;
            $display("FAIL stall_m_release: rd_w=%0d wen_w=%b rd_m=%0d wen_m=%b want 9 1 11 1",
                     rd_w, wen_w, rd_m, wen_m);
        end
        drain();
    endtask

    task automatic test_flush();
        drive_e(1'b1, 5'd4, 1'b1, 1'b0);
        drive_e(1'b1, 5'd3, 1'b1, 1'b0);
        flush = 1'b1;
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        flush = 1'b0;
        #1;
        vec_cnt++;
        if (wen_m !== 1'b0 || wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush: wen_m=%b wen_w=%b want 0 0", wen_m, wen_w);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        #1;
        vec_cnt++;
        if (wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_drain: wen_w=%b want 0", wen_w);
        end
        // Flush during stall_m: flush wins, M clears and W bubbles.
        drive_e(1'b1, 5'd8, 1'b1, 1'b0);
        drive_e(1'b1, 5'd2, 1'b1, 1'b0);
        stall_m = 1'b1;
        flush   = 1'b1;
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        stall_m = 1'b0;
        flush   = 1'b0;
        #1;
        vec_cnt++;
        if (wen_m !== 1'b0 || wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL flush_stall: wen_m=%b wen_w=%b want 0 0", wen_m, wen_w);
        end
        drain();
    endtask

    task automatic test_async_reset();
        drive_e(1'b1, 5'd6, 1'b1, 1'b0);
        drive_e(1'b1, 5'd14, 1'b1, 1'b0);
        #1;
        vec_cnt++;
        if (rd_m !== 5'd6 || wen_m !== 1'b1) begin
            err_cnt++;
            $display("FAIL pre_reset: rd_m=%0d wen_m=%b want 6 1", rd_m, wen_m);
        end
        idle_inputs();
        #1;
        reset = 1'b1;
        #1;
        vec_cnt++;
        if (rd_m !== 5'd0 || wen_m !== 1'b0 || rd_w !== 5'd0 || wen_w !== 1'b0 || stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL async_reset: rd_m=%0d wen_m=%b rd_w=%0d wen_w=%b stall_d=%b want all 0",
                     rd_m, wen_m, rd_w, wen_w, stall_d);
        end
        @(negedge clk);
        reset = 1'b0;
        drain();
    endtask

`ifdef CPU7_DIV_SCOREBOARD_EN
    task automatic test_div_scoreboard();
        drive_e(1'b1, 5'd12, 1'b1, 1'b0);
        div_issue_e = 1'b1;
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_issue_e = 1'b0;
        set_d(5'd12, 1'b1, 5'd0, 1'b0);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1 || wen_m !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_busy: stall_d=%b wen_m=%b want 1 0", stall_d, wen_m);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_done = 1'b1;
        div_rd   = 5'd12;
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1 || wen_w !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_busy2: stall_d=%b wen_w=%b want 1 0", stall_d, wen_w);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_done = 1'b0;
        div_rd   = 5'd0;
        #1;
        vec_cnt++;
        if (wen_w !== 1'b1 || rd_w !== 5'd12 || stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_wb: wen_w=%b rd_w=%0d stall_d=%b want 1 12 0", wen_w, rd_w, stall_d);
        end
        set_d(5'd0, 1'b0, 5'd0, 1'b0);
        drive_e(1'b1, 5'd12, 1'b1, 1'b0);
        div_issue_e = 1'b1;
        drive_e(1'b1, 5'd12, 1'b1, 1'b0);
        div_done = 1'b1;
        div_rd   = 5'd12;
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_issue_e = 1'b0;
        div_done    = 1'b0;
        div_rd      = 5'd0;
        set_d(5'd0, 1'b0, 5'd12, 1'b1);
        #1;
        vec_cnt++;
        if (stall_d !== 1'b1) begin
            err_cnt++;
            $display("FAIL div_set_wins: stall_d=%b want 1", stall_d);
        end
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_done = 1'b1;
        div_rd   = 5'd12;
        drive_e(1'b0, 5'd0, 1'b0, 1'b0);
        div_done = 1'b0;
        div_rd   = 5'd0;
        #1;
        vec_cnt++;
        if (stall_d !== 1'b0) begin
            err_cnt++;
            $display("FAIL div_cleared: stall_d=%b want 0", stall_d);
        end
        drain();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_r0_filter();
        test_stall_m();
        test_flush();
        test_async_reset();
`ifdef CPU7_DIV_SCOREBOARD_EN
        test_div_scoreboard();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
